// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// fetch_sequencer_pkg : opcodes, FSM states and instruction field positions
// Revision 1.0
// ============================================================================
package fetch_sequencer_pkg;

  localparam logic [3:0] JMP_OP  = 4'd9;
  localparam logic [3:0] CALL_OP = 4'd10;
  localparam logic [3:0] RET_OP  = 4'd11;
  localparam logic [3:0] HALT_OP = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int OFF_MSB = 7;
  localparam int OFF_LSB = 0;

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_return_stack.sv
`default_nettype none
// ============================================================================
// return_stack : LIFO of return addresses, DEPTH entries of W bits
// Revision 1.0
// ============================================================================
module return_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] count;
  logic [CW-1:0] top;

  assign top   = count - CW'(1);
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign dout  = mem[top[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CW'(1);
    end else if (pop && !empty) begin
      count <= count - CW'(1);
    end
  end

  // Storage needs no reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[count[AW-1:0]] <= din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// fetch_sequencer : PC owner and fetch/execute sequencer for the instruction ROM
// Revision 1.0
// ============================================================================
module fetch_sequencer #(
  parameter int         PC_W        = 8,
  parameter int         STACK_DEPTH = 4,
  parameter logic [3:0] JMP_OP      = fetch_sequencer_pkg::JMP_OP,
  parameter logic [3:0] CALL_OP     = fetch_sequencer_pkg::CALL_OP,
  parameter logic [3:0] RET_OP      = fetch_sequencer_pkg::RET_OP,
  parameter logic [3:0] HALT_OP     = fetch_sequencer_pkg::HALT_OP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stall,
  input  logic [15:0]     gvn_instr,
  output logic [PC_W-1:0] PCout,
  output logic [PC_W-1:0] PC_out,
  output logic [3:0]      opcode,
  output logic            instr_valid,
  output logic            halted,
  output logic            stack_err
);
  import fetch_sequencer_pkg::*;

  state_t          state;
  logic [3:0]      op;
  logic [7:0]      off;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] jmp_tgt;
  logic [PC_W-1:0] ret_addr;
  logic            exec_go;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic            unused_bits;

  assign op          = gvn_instr[OP_MSB:OP_LSB];
  assign off         = gvn_instr[OFF_MSB:OFF_LSB];
  assign unused_bits = ^gvn_instr[11:8];
  assign pc_inc      = PCout + PC_W'(1);
  assign jmp_tgt     = PCout + PC_W'(off);
  assign exec_go     = (state == S_EXEC) && !stall;
  assign push        = exec_go && (op == CALL_OP) && !full;
  assign pop         = exec_go && (op == RET_OP) && !empty;

  return_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (ret_addr),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      PCout       <= '0;
      PC_out      <= '0;
      opcode      <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      stack_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state <= S_FETCH;
        end
        S_FETCH: begin
          if (!stall) begin
            state       <= S_EXEC;
            instr_valid <= 1'b1;
          end
        end
        S_EXEC: begin
          if (!stall) begin
            instr_valid <= 1'b0;
            opcode      <= op;
            state       <= S_FETCH;
            // PC_out tracks PCout on every path so a jump opcode never exposes a stale target.
            case (op)
              JMP_OP: begin
                PCout  <= jmp_tgt;
                PC_out <= jmp_tgt;
              end
              CALL_OP: begin
                if (!full) begin
                  PCout  <= PC_W'(off);
                  PC_out <= PC_W'(off);
                end else begin
                  stack_err <= 1'b1;
                  PCout     <= pc_inc;
                  PC_out    <= pc_inc;
                end
              end
              RET_OP: begin
                if (!empty) begin
                  PCout  <= ret_addr;
                  PC_out <= ret_addr;
                end else begin
                  stack_err <= 1'b1;
                  PCout     <= pc_inc;
                  PC_out    <= pc_inc;
                end
              end
              HALT_OP: begin
                state  <= S_HALT;
                halted <= 1'b1;
              end
              default: begin
                PCout  <= pc_inc;
                PC_out <= pc_inc;
              end
            endcase
          end
        end
        S_HALT: begin
          halted <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// tb_fetch_sequencer : directed bench with ROM model and expected-address scoreboard
// Revision 1.0
// ============================================================================
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stall;
  logic [15:0] gvn_instr = 16'h0000;
  logic [7:0]  PCout;
  logic [7:0]  PC_out;
  logic [3:0]  opcode;
  logic        instr_valid;
  logic        halted;
  logic        stack_err;

  logic [15:0] rom [256];
  logic [7:0]  rom_addr = 8'h00;
  logic [7:0]  fetch_addr;
  logic [7:0]  sb [$];
  int          tests = 0;
  int          fails = 0;
  bit          gap_on = 1'b0;

  fetch_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stall       (stall),
    .gvn_instr   (gvn_instr),
    .PCout       (PCout),
    .PC_out      (PC_out),
    .opcode      (opcode),
    .instr_valid (instr_valid),
    .halted      (halted),
    .stack_err   (stack_err)
  );

  always #5 clk = ~clk;

  // ROM model: address sampled mid-cycle, registered word appears just after the edge.
  assign fetch_addr = (opcode == 4'd9) ? PC_out : PCout;
  always @(negedge clk) rom_addr = fetch_addr;
  always @(posedge clk) begin
    #1;
    gvn_instr = rom[rom_addr];
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  task automatic reset_dut();
    rst   = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    chk("rst_PCout", 16'(PCout), 16'h0);
    chk("rst_PC_out", 16'(PC_out), 16'h0);
    chk("rst_opcode", 16'(opcode), 16'h0);
    chk("rst_valid", 16'(instr_valid), 16'h0);
    chk("rst_halted", 16'(halted), 16'h0);
    chk("rst_stack_err", 16'(stack_err), 16'h0);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_dut();
    gap_on = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Waits for the next EXEC cycle and checks it against the head of the scoreboard.
  task automatic check_next();
    int n;
    logic [7:0] exp;
    n = 0;
    @(negedge clk);
    while (!instr_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("instr_valid", 16'(instr_valid), 16'h1);
    if (gap_on) chk("valid_gap", 16'(n), 16'h1);
    exp = sb.pop_front();
    chk("exec_addr", 16'(fetch_addr), 16'(exp));
    chk("exec_instr", gvn_instr, rom[exp]);
    gap_on = 1'b1;
  endtask

  task automatic drain();
    while (sb.size() > 0) check_next();
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stall = 1'b0;

    // Straight-line NOPs through the 255 -> 0 wrap
    clear_rom();
    reset_dut(); start_dut();
    for (int a = 0; a < 256; a++) sb.push_back(8'(a));
    sb.push_back(8'd0); sb.push_back(8'd1);
    drain();

    // Relative jumps, including one that wraps
    clear_rom(); rom[3] = 16'h9005; rom[250] = 16'h900A;
    reset_dut(); start_dut();
    for (int a = 0; a < 4; a++) sb.push_back(8'(a));
    sb.push_back(8'd8);
    drain();
    chk("jmp_PCout", 16'(PCout), 16'h8);
    chk("jmp_PC_out", 16'(PC_out), 16'h8);
    chk("jmp_opcode", 16'(opcode), 16'h9);
    for (int a = 9; a < 251; a++) sb.push_back(8'(a));
    sb.push_back(8'd4);
    drain();
    chk("jmpwrap_PCout", 16'(PCout), 16'h4);
    chk("jmpwrap_PC_out", 16'(PC_out), 16'h4);

    // Call and return
    clear_rom(); rom[2] = 16'hA040; rom[8'h40] = 16'hB000;
    reset_dut(); start_dut();
    sb.push_back(8'd0); sb.push_back(8'd1); sb.push_back(8'd2); sb.push_back(8'h40);
    drain();
    chk("call_opcode", 16'(opcode), 16'hA);
    chk("call_PC_out", 16'(PC_out), 16'h40);
    sb.push_back(8'd3); sb.push_back(8'd4);
    drain();
    chk("callret_err", 16'(stack_err), 16'h0);

    // Return on an empty stack
    clear_rom(); rom[0] = 16'hB000;
    reset_dut(); start_dut();
    sb.push_back(8'd0); sb.push_back(8'd1);
    drain();
    chk("ret_empty_err", 16'(stack_err), 16'h1);

    // Five nested calls overflow the four-entry stack
    clear_rom();
    rom[1] = 16'hA010; rom[8'h10] = 16'hA020; rom[8'h20] = 16'hA030;
    rom[8'h30] = 16'hA040; rom[8'h40] = 16'hA050;
    rom[8'h41] = 16'hB000; rom[8'h31] = 16'hB000; rom[8'h21] = 16'hB000; rom[8'h11] = 16'hB000;
    reset_dut(); start_dut();
    sb.push_back(8'd0); sb.push_back(8'd1); sb.push_back(8'h10);
    sb.push_back(8'h20); sb.push_back(8'h30); sb.push_back(8'h40);
    drain();
    chk("nest4_err", 16'(stack_err), 16'h0);
    sb.push_back(8'h41);
    drain();
    chk("nest5_err", 16'(stack_err), 16'h1);
    sb.push_back(8'h31); sb.push_back(8'h21); sb.push_back(8'h11);
    sb.push_back(8'd2); sb.push_back(8'd3);
    drain();

    // Stall in EXEC, then halt
    clear_rom(); rom[2] = 16'h1234; rom[5] = 16'hF000;
    reset_dut(); start_dut();
    sb.push_back(8'd0); sb.push_back(8'd1); sb.push_back(8'd2);
    drain();
    stall = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_PCout", 16'(PCout), 16'h2);
      chk("stall_instr", gvn_instr, 16'h1234);
      chk("stall_valid", 16'(instr_valid), 16'h1);
    end
    stall = 1'b0;
    sb.push_back(8'd3);
    drain();
    chk("generic_opcode", 16'(opcode), 16'h1);
    chk("generic_PC_out", 16'(PC_out), 16'h3);
    sb.push_back(8'd4); sb.push_back(8'd5);
    drain();
    repeat (2) @(negedge clk);
    chk("halt_halted", 16'(halted), 16'h1);
    chk("halt_PCout", 16'(PCout), 16'h5);
    chk("halt_opcode", 16'(opcode), 16'hF);
    chk("halt_valid", 16'(instr_valid), 16'h0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("halt_start_halted", 16'(halted), 16'h1);
    chk("halt_start_PCout", 16'(PCout), 16'h5);
    chk("halt_start_valid", 16'(instr_valid), 16'h0);

    // Asynchronous reset in the middle of a CALL's EXEC
    clear_rom(); rom[1] = 16'h3000; rom[2] = 16'hA040;
    reset_dut(); start_dut();
    sb.push_back(8'd0); sb.push_back(8'd1); sb.push_back(8'd2);
    drain();
    #2 rst = 1'b0;
    #1;
    chk("async_PCout", 16'(PCout), 16'h0);
    chk("async_PC_out", 16'(PC_out), 16'h0);
    chk("async_opcode", 16'(opcode), 16'h0);
    chk("async_valid", 16'(instr_valid), 16'h0);
    reset_dut();
    rom[0] = 16'hB000;
    start_dut();
    sb.push_back(8'd0); sb.push_back(8'd1);
    drain();
    chk("async_ret_err", 16'(stack_err), 16'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
